alu_cmd_ctrl: RTL

//  Command-side initiator for the ALU: assembles byte-wide command frames from the RX path,

---
 rtl/alu_cmd_ctrl_if.sv | 32 +++
 rtl/alu_cmd_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl_if.sv
// Bus bundle between the ALU command controller and its RX/TX synchronisers and ALU.
// master = controller side, slave = environment (RX/TX path and ALU).
interface alu_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [ALU_WIDTH-1:0]  alu_a;
    logic [ALU_WIDTH-1:0]  alu_b;
    logic [FUN_WIDTH-1:0]  alu_fun;
    logic                  alu_en;
    logic                  clk_gate_en;
    logic [ALU_WIDTH-1:0]  alu_out;
    logic                  alu_out_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  busy;
    logic                  err_pulse;

    modport master (
        input  rx_data, rx_valid, alu_out, alu_out_valid, tx_ready,
        output alu_a, alu_b, alu_fun, alu_en, clk_gate_en, tx_data, tx_valid, busy, err_pulse
    );

    modport slave (
        output rx_data, rx_valid, alu_out, alu_out_valid, tx_ready,
        input  alu_a, alu_b, alu_fun, alu_en, clk_gate_en, tx_data, tx_valid, busy, err_pulse
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: parses OP/REPEAT frames from RX, runs one ALU operation with a
// timeout, and returns the 16-bit result as two bytes (low first) over valid/ready TX.
module alu_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic           clk,
    input  logic           async_rst,
    alu_cmd_ctrl_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_RPT = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_GET_A0, S_GET_A1, S_GET_B0, S_GET_B1,
        S_GET_FUN, S_ALU_REQ, S_ALU_WAIT, S_TX_LO, S_TX_HI
    } state_t;

    state_t                 r_state, w_next;
    logic                   w_err, w_cap, w_cnt_inc;
    logic [CNT_W-1:0]       r_cnt;
    logic [ALU_WIDTH-1:0]   r_a, r_b;
    logic [FUN_WIDTH-1:0]   r_fun;
    logic [DATA_WIDTH-1:0]  r_res_hi, r_tx_data;
    logic                   r_alu_en, r_gate, r_tx_valid, r_busy, r_err;

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_err     = 1'b0;
        w_cap     = 1'b0;
        w_cnt_inc = 1'b0;
        case (r_state)
            S_IDLE: if (bus.rx_valid) begin
                if (bus.rx_data == CMD_OP)       w_next = S_GET_A0;
                else if (bus.rx_data == CMD_RPT) w_next = S_GET_FUN;
                else                             w_err  = 1'b1;
            end
            S_GET_A0:  if (bus.rx_valid) w_next = S_GET_A1;
            S_GET_A1:  if (bus.rx_valid) w_next = S_GET_B0;
            S_GET_B0:  if (bus.rx_valid) w_next = S_GET_B1;
            S_GET_B1:  if (bus.rx_valid) w_next = S_GET_FUN;
            S_GET_FUN: if (bus.rx_valid) w_next = S_ALU_REQ;
            S_ALU_REQ: w_next = S_ALU_WAIT;
            S_ALU_WAIT: begin
                if (bus.alu_out_valid) begin
                    w_cap  = 1'b1;
                    w_next = S_TX_LO;
                end else if (r_cnt == CNT_MAX) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_TX_LO: if (bus.tx_ready) w_next = S_TX_HI;
            S_TX_HI: if (bus.tx_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Single-bit outputs are registered from the next state so they are glitch-free
    // and line up exactly with the state they describe.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_alu_en   <= 1'b0;
            r_gate     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_alu_en   <= (w_next == S_ALU_REQ);
            r_gate     <= (w_next == S_ALU_REQ) || (w_next == S_ALU_WAIT);
            r_tx_valid <= (w_next == S_TX_LO) || (w_next == S_TX_HI);
            r_busy     <= (w_next != S_IDLE);
            r_err      <= w_err;
        end
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_fun     <= '0;
            r_cnt     <= '0;
            r_res_hi  <= '0;
            r_tx_data <= '0;
        end else begin
            if (bus.rx_valid) begin
                case (r_state)
                    S_GET_A0:  r_a[DATA_WIDTH-1:0]         <= bus.rx_data;
                    S_GET_A1:  r_a[ALU_WIDTH-1:DATA_WIDTH] <= bus.rx_data;
                    S_GET_B0:  r_b[DATA_WIDTH-1:0]         <= bus.rx_data;
                    S_GET_B1:  r_b[ALU_WIDTH-1:DATA_WIDTH] <= bus.rx_data;
                    S_GET_FUN: r_fun                       <= bus.rx_data[FUN_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (r_state == S_ALU_REQ) r_cnt <= '0;
            else if (w_cnt_inc)       r_cnt <= r_cnt + 1'b1;
            // Low byte goes straight to tx_data; only the high byte needs holding.
            if (w_cap) begin
                r_res_hi  <= bus.alu_out[ALU_WIDTH-1:DATA_WIDTH];
                r_tx_data <= bus.alu_out[DATA_WIDTH-1:0];
            end else if (r_state == S_TX_LO && bus.tx_ready) begin
                r_tx_data <= r_res_hi;
            end
        end
    end

    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;
    assign bus.alu_fun     = r_fun;
    assign bus.alu_en      = r_alu_en;
    assign bus.clk_gate_en = r_gate;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_valid    = r_tx_valid;
    assign bus.busy        = r_busy;
    assign bus.err_pulse   = r_err;
endmodule
